set_cache: RTL and testbench
============================

# set_cache

Parametrised direct-mapped, multi-line write-back cache. It sits between a tensor-worker load/store port and the line-wide external memory controller. It generalises the single-line cache to 2^SET_BITS lines of configurable width. It adds per-line valid/dirty tracking, eviction write-back, working write-through/read-through modes and a whole-cache flush.

## Interface
- LINE_BITS, default 8: byte-offset bits per line; line holds 2^(LINE_BITS-2) 32-bit words (default 64).
- SET_BITS, default 2: index bits; 2^SET_BITS lines (default 4).
- clk  in  1  system clock.
- rst_l  in  1  reset. One clock; reset is asynchronous and active-low.
- w_en, r_en  in  1 each  request strobes, held until done.
- write_through, read_through  in  1 each  per-request mode, sampled with the request.
- addr  in  [25:2]  word address: offset addr[LINE_BITS-1:2], set addr[LINE_BITS+SET_BITS-1:LINE_BITS], tag above.
- data_store  in  32  write data.
- data_load  out  32  read data, valid only while done=1.
- done  out  1  one-cycle completion pulse.
- cache_hit  out  1  qualifies done: request served without memory traffic.
- flush  in  1  write back all dirty lines; held until flush_done.
- flush_done  out  1  one-cycle pulse.
- line_read  in  [2^(LINE_BITS-2)-1:0][31:0]  fill data.
- line_store  out  same width  write-back data.
- mem_ready, mem_done  in  1 each  memory idle / operation complete.
- mem_w_en, mem_r_en  out  1 each  line write / line read command.
- mem_addr  out  [25:2]  line base address, offset bits zero.

## Operation
- States: IDLE, HIT, WB, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - flush → FLUSH_SCAN; flush has priority over r_en/w_en.
  - Request that hits (valid, tag match, not read_through) → HIT.
  - Any other request is a miss. It waits in IDLE until mem_ready=1.
  - On a miss, a dirty victim → WB; a clean or invalid victim → FILL.
  - w_en and r_en together is illegal; the request is treated as a write.
- HIT: done=1. data_load = stored word.
  - Write: word updated at the clock edge leaving HIT, dirty set, cache_hit=1.
  - With write_through, the write also goes to memory: next state WB (dirty cleared on its completion), done instead pulses when the write-back finishes, cache_hit=0.
  - Otherwise → IDLE.
- WB: mem_w_en=1, mem_addr={victim tag, set, 0}, line_store=victim line. Held until mem_done.
  - On mem_done, dirty is cleared. Then FILL if a miss is pending, else IDLE with done=1 (write-through completion).
- FILL: mem_r_en=1, mem_addr=requested line base. Held until mem_done.
  - On mem_done: line_read written to the set, tag loaded, valid=1, dirty=0; → HIT.
  - The HIT that follows a fill reports cache_hit=0.
- FLUSH_SCAN: set counter walks 0..2^SET_BITS-1, one set per cycle.
  - A valid dirty set → FLUSH_WB, same drive as WB.
  - After the last set: flush_done=1 → IDLE.
  - Lines stay valid after flush.
- Memory enables are only ever asserted in WB/FILL/FLUSH_WB. A mem_done seen in other states is ignored.

## Timing
- Reset (asynchronous): state IDLE, all valid/dirty bits 0, flush counter 0. done, cache_hit, flush_done, mem_w_en, mem_r_en, data_load, line_store, mem_addr all 0.
- Reset mid-operation drops memory enables immediately. The in-flight memory operation is abandoned and the cache comes up empty.
- Hit: request seen in IDLE at cycle N; done at N+1.
- Clean miss, mem_ready=1 at N: FILL from N+1. mem_done at cycle M gives done at M+1.
- Dirty miss: WB from N+1 to mem_done at M1, FILL from M1+1 to mem_done at M2, done at M2+1.
- Requester deasserts r_en/w_en the cycle after done, or presents the next request. A request held after done starts a new access.
- mem_done must be a single-cycle pulse. Memory enables are combinational from state.
- Flush of an all-clean cache: flush_done 2^SET_BITS+1 cycles after flush is seen.

## Structure
- Package cache_pkg: state enum, typedefs for line_t, tag_t, set_t derived from LINE_BITS/SET_BITS, and the address-slicing helper functions.
- Sub-module cache_line_store: tag/valid/dirty arrays plus data array. Word write port, full-line write port, combinational read of one line by set. The FSM stays in set_cache.

## Test plan
- Reset, write 0xDEADBEEF to addr 0x000010 (miss, clean) → FILL at base 0x000000; done with cache_hit=0. Read of 0x000010 → done next cycle, cache_hit=1, data 0xDEADBEEF.
- Dirty conflict: write to 0x000010, then read 0x000110 (same set 0, new tag) → WB to 0x000000 with word 16 = 0xDEADBEEF, then FILL at 0x000100, data = line_read word 16.
- write_through write of 0x12345678 to a resident line → WB carries the word, done after mem_done, line left clean.
- read_through read of a resident clean line → FILL issued despite tag match, cache_hit=0.
- Dirty sets 1 and 3, assert flush → exactly two WB operations, in set order, then flush_done; a later read of set 1 hits.
- Assert rst_l=0 during FILL → mem_r_en drops the same cycle; after release, a read of the previously resident address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped set cache.
// Word addresses are 24 bits: {tag, set, offset}.
package cache_pkg;

    localparam int LINE_BITS_DEF = 8;
    localparam int SET_BITS_DEF  = 2;
    localparam int WORDS_DEF     = 2 ** (LINE_BITS_DEF - 2);
    localparam int TAG_W_DEF     = 26 - LINE_BITS_DEF - SET_BITS_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_WB,
        S_FILL,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } state_t;

    typedef logic [WORDS_DEF-1:0][31:0] line_t;
    typedef logic [TAG_W_DEF-1:0]       tag_t;
    typedef logic [SET_BITS_DEF-1:0]    set_t;
    typedef logic [23:0]                waddr_t;

    function automatic waddr_t addr_off(waddr_t a, int lb);
        return a & ((waddr_t'(1) << (lb - 2)) - waddr_t'(1));
    endfunction

    function automatic waddr_t addr_set(waddr_t a, int lb, int sb);
        return (a >> (lb - 2)) & ((waddr_t'(1) << sb) - waddr_t'(1));
    endfunction

    function automatic waddr_t addr_tag(waddr_t a, int lb, int sb);
        return a >> (lb - 2 + sb);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty state and line data for every set.
// One combinational read line; word and full-line write ports.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int SET_BITS  = SET_BITS_DEF
) (
    input  logic clk,
    input  logic rst_l,
    input  logic [SET_BITS-1:0] sel,
    output logic [2**(LINE_BITS-2)-1:0][31:0] rd_line,
    output logic [25-LINE_BITS-SET_BITS:0] rd_tag,
    output logic rd_valid,
    output logic rd_dirty,
    input  logic ww_en,
    input  logic [LINE_BITS-3:0] ww_off,
    input  logic [31:0] ww_data,
    input  logic lw_en,
    input  logic [25-LINE_BITS-SET_BITS:0] lw_tag,
    input  logic [2**(LINE_BITS-2)-1:0][31:0] lw_data,
    input  logic clr_en
);

    localparam int WORDS = 2 ** (LINE_BITS - 2);
    localparam int TAG_W = 26 - LINE_BITS - SET_BITS;
    localparam int NSETS = 2 ** SET_BITS;

    logic [NSETS-1:0]            valid_q;
    logic [NSETS-1:0]            dirty_q;
    logic [NSETS-1:0][TAG_W-1:0] tag_q;
    logic [WORDS-1:0][31:0]      data_q [NSETS];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
        end else if (lw_en) begin
            valid_q[sel] <= 1'b1;
            dirty_q[sel] <= 1'b0;
            tag_q[sel]   <= lw_tag;
        end else if (ww_en) begin
            dirty_q[sel] <= 1'b1;
        end else if (clr_en) begin
            dirty_q[sel] <= 1'b0;
        end
    end

    // Data needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        if (lw_en) begin
            data_q[sel] <= lw_data;
        end else if (ww_en) begin
            data_q[sel][ww_off] <= ww_data;
        end
    end

    assign rd_line  = data_q[sel];
    assign rd_tag   = tag_q[sel];
    assign rd_valid = valid_q[sel];
    assign rd_dirty = dirty_q[sel];

endmodule

// File: rtl/set_cache.sv
// Direct-mapped write-back cache between a load/store port and a
// line-wide memory controller, with write/read-through and flush.
module set_cache
    import cache_pkg::*;
#(
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int SET_BITS  = SET_BITS_DEF
) (
    input  logic clk,
    input  logic rst_l,
    input  logic w_en,
    input  logic r_en,
    input  logic write_through,
    input  logic read_through,
    input  logic [25:2] addr,
    input  logic [31:0] data_store,
    output logic [31:0] data_load,
    output logic done,
    output logic cache_hit,
    input  logic flush,
    output logic flush_done,
    input  logic [2**(LINE_BITS-2)-1:0][31:0] line_read,
    output logic [2**(LINE_BITS-2)-1:0][31:0] line_store,
    input  logic mem_ready,
    input  logic mem_done,
    output logic mem_w_en,
    output logic mem_r_en,
    output logic [25:2] mem_addr
);

    localparam int OFF_W = LINE_BITS - 2;
    localparam int TAG_W = 26 - LINE_BITS - SET_BITS;
    localparam int CNT_W = SET_BITS + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(2 ** SET_BITS);

    typedef logic [OFF_W-1:0]    coff_t;
    typedef logic [SET_BITS-1:0] cset_t;
    typedef logic [TAG_W-1:0]    ctag_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    waddr_t            req_addr_q;
    logic [31:0]       req_data_q;
    logic              req_write_q;
    logic              req_wt_q;
    logic              pend_q, pend_d;
    logic              filled_q, filled_d;
    logic              latch;

    logic [2**(LINE_BITS-2)-1:0][31:0] rd_line;
    ctag_t rd_tag;
    logic  rd_valid, rd_dirty;
    logic  ww_en, lw_en, clr_en;

    cset_t in_set, req_set, cur_set;
    ctag_t in_tag, req_tag;
    coff_t req_off;
    logic  req, hit_in, victim_dirty;

    assign in_set  = cset_t'(addr_set(addr, LINE_BITS, SET_BITS));
    assign in_tag  = ctag_t'(addr_tag(addr, LINE_BITS, SET_BITS));
    assign req_set = cset_t'(addr_set(req_addr_q, LINE_BITS, SET_BITS));
    assign req_tag = ctag_t'(addr_tag(req_addr_q, LINE_BITS, SET_BITS));
    assign req_off = coff_t'(addr_off(req_addr_q, LINE_BITS));

    assign req          = w_en | r_en;
    assign hit_in       = rd_valid && (rd_tag == in_tag) && !read_through;
    assign victim_dirty = rd_valid && rd_dirty;

    always_comb begin
        cur_set = req_set;
        if (state_q == S_IDLE) begin
            cur_set = in_set;
        end else if (state_q == S_FLUSH_SCAN || state_q == S_FLUSH_WB) begin
            cur_set = cnt_q[SET_BITS-1:0];
        end
    end

    cache_line_store #(
        .LINE_BITS(LINE_BITS),
        .SET_BITS (SET_BITS)
    ) u_store (
        .clk     (clk),
        .rst_l   (rst_l),
        .sel     (cur_set),
        .rd_line (rd_line),
        .rd_tag  (rd_tag),
        .rd_valid(rd_valid),
        .rd_dirty(rd_dirty),
        .ww_en   (ww_en),
        .ww_off  (req_off),
        .ww_data (req_data_q),
        .lw_en   (lw_en),
        .lw_tag  (req_tag),
        .lw_data (line_read),
        .clr_en  (clr_en)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_write_q <= 1'b0;
            req_wt_q    <= 1'b0;
            pend_q      <= 1'b0;
            filled_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            filled_q <= filled_d;
            if (latch) begin
                req_addr_q  <= addr;
                req_data_q  <= data_store;
                req_write_q <= w_en;
                req_wt_q    <= write_through;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        filled_d   = filled_q;
        latch      = 1'b0;
        done       = 1'b0;
        cache_hit  = 1'b0;
        flush_done = 1'b0;
        mem_w_en   = 1'b0;
        mem_r_en   = 1'b0;
        mem_addr   = '0;
        line_store = '0;
        data_load  = '0;
        ww_en      = 1'b0;
        lw_en      = 1'b0;
        clr_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH_SCAN;
                    cnt_d   = '0;
                end else if (req) begin
                    latch = 1'b1;
                    if (hit_in) begin
                        state_d  = S_HIT;
                        filled_d = 1'b0;
                    end else if (mem_ready) begin
                        pend_d  = 1'b1;
                        state_d = victim_dirty ? S_WB : S_FILL;
                    end
                end
            end
            S_HIT: begin
                data_load = rd_line[req_off];
                ww_en     = req_write_q;
                if (req_write_q && req_wt_q) begin
                    pend_d  = 1'b0;
                    state_d = S_WB;
                end else begin
                    done      = 1'b1;
                    cache_hit = !filled_q;
                    state_d   = S_IDLE;
                end
            end
            S_WB: begin
                mem_w_en   = 1'b1;
                mem_addr   = {rd_tag, cur_set, {OFF_W{1'b0}}};
                line_store = rd_line;
                if (mem_done) begin
                    clr_en = 1'b1;
                    if (pend_q) begin
                        state_d = S_FILL;
                    end else begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FILL: begin
                mem_r_en = 1'b1;
                mem_addr = {req_tag, req_set, {OFF_W{1'b0}}};
                if (mem_done) begin
                    lw_en    = 1'b1;
                    filled_d = 1'b1;
                    state_d  = S_HIT;
                end
            end
            S_FLUSH_SCAN: begin
                // Extra step past the last set is the flush_done cycle.
                if (cnt_q == CNT_END) begin
                    flush_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else if (victim_dirty) begin
                    state_d = S_FLUSH_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH_WB: begin
                mem_w_en   = 1'b1;
                mem_addr   = {rd_tag, cur_set, {OFF_W{1'b0}}};
                line_store = rd_line;
                if (mem_done) begin
                    clr_en  = 1'b1;
                    state_d = S_FLUSH_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_set_cache.sv
// Directed bench for set_cache with a fixed-latency line memory.
// Memory returns word i of line b as {b[15:0], 8'hA5, i[7:0]}.
module tb_set_cache;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_l, w_en, r_en, write_through, read_through;
    logic [25:2] addr;
    logic [31:0] data_store, data_load;
    logic done, cache_hit, flush, flush_done;
    logic [63:0][31:0] line_read, line_store;
    logic mem_ready;
    logic mem_done = 1'b0;
    logic mem_w_en, mem_r_en;
    logic [25:2] mem_addr;

    int checks = 0;
    int failures = 0;

    set_cache dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .w_en         (w_en),
        .r_en         (r_en),
        .write_through(write_through),
        .read_through (read_through),
        .addr         (addr),
        .data_store   (data_store),
        .data_load    (data_load),
        .done         (done),
        .cache_hit    (cache_hit),
        .flush        (flush),
        .flush_done   (flush_done),
        .line_read    (line_read),
        .line_store   (line_store),
        .mem_ready    (mem_ready),
        .mem_done     (mem_done),
        .mem_w_en     (mem_w_en),
        .mem_r_en     (mem_r_en),
        .mem_addr     (mem_addr)
    );

    function automatic logic [31:0] lr(input logic [23:0] b, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return {b[15:0], 8'hA5, ib};
    endfunction

    always_comb begin
        for (int i = 0; i < 64; i++) line_read[i] = lr(mem_addr, i);
    end

    logic        lw_q[$];
    logic [23:0] la_q[$];
    logic [31:0] ld_q[$];
    int dly = 0;

    // Each memory op completes on its third cycle with enables high.
    always @(posedge clk) begin
        #2;
        if (mem_done) begin
            mem_done = 1'b0;
            dly = 0;
        end else if (mem_w_en || mem_r_en) begin
            dly++;
            if (dly == 3) begin
                mem_done = 1'b1;
                lw_q.push_back(mem_w_en);
                la_q.push_back(mem_addr);
                ld_q.push_back(line_store[16]);
            end
        end else begin
            dly = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic wt, input logic rt,
                          input logic [23:0] a, input logic [31:0] d,
                          output logic hit, output logic [31:0] q,
                          output int lat);
        @(negedge clk);
        w_en = w;
        r_en = !w;
        write_through = wt;
        read_through = rt;
        addr = a;
        data_store = d;
        hit = 1'b0;
        q = '0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                hit = cache_hit;
                q = data_load;
                lat = i;
                break;
            end
        end
        w_en = 1'b0;
        r_en = 1'b0;
        write_through = 1'b0;
        read_through = 1'b0;
    endtask

    task automatic do_flush(output int lat);
        @(negedge clk);
        flush = 1'b1;
        lat = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (flush_done) begin
                lat = i;
                break;
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic hit;
    logic [31:0] q;
    int lat, n0;

    initial begin
        rst_l = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        write_through = 1'b0;
        read_through = 1'b0;
        addr = '0;
        data_store = '0;
        flush = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_hit", cache_hit, 0);
        chk("rst_fdone", flush_done, 0);
        chk("rst_mwen", mem_w_en, 0);
        chk("rst_mren", mem_r_en, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_dload", data_load, 0);
        chk("rst_lstore", line_store == '0, 1);
        rst_l = 1'b1;

        // clean write miss
        n0 = lw_q.size();
        do_req(1, 0, 0, 24'h000010, 32'hDEADBEEF, hit, q, lat);
        chk("wmiss_lat", lat, 4);
        chk("wmiss_hit", hit, 0);
        chk("wmiss_nops", lw_q.size() - n0, 1);
        chk("wmiss_op", lw_q[n0], 0);
        chk("wmiss_addr", la_q[n0], 24'h000000);

        // read hit
        n0 = lw_q.size();
        do_req(0, 0, 0, 24'h000010, 0, hit, q, lat);
        chk("rhit_lat", lat, 1);
        chk("rhit_hit", hit, 1);
        chk("rhit_data", q, 32'hDEADBEEF);
        chk("rhit_nops", lw_q.size() - n0, 0);

        // dirty conflict miss
        n0 = lw_q.size();
        do_req(0, 0, 0, 24'h000110, 0, hit, q, lat);
        chk("dmiss_lat", lat, 8);
        chk("dmiss_hit", hit, 0);
        chk("dmiss_data", q, 32'h0100A510);
        chk("dmiss_nops", lw_q.size() - n0, 2);
        chk("dmiss_wb_op", lw_q[n0], 1);
        chk("dmiss_wb_addr", la_q[n0], 24'h000000);
        chk("dmiss_wb_w16", ld_q[n0], 32'hDEADBEEF);
        chk("dmiss_fill_op", lw_q[n0+1], 0);
        chk("dmiss_fill_addr", la_q[n0+1], 24'h000100);

        // write-through on resident line
        n0 = lw_q.size();
        do_req(1, 1, 0, 24'h000110, 32'h12345678, hit, q, lat);
        chk("wt_lat", lat, 4);
        chk("wt_hit", hit, 0);
        chk("wt_nops", lw_q.size() - n0, 1);
        chk("wt_op", lw_q[n0], 1);
        chk("wt_addr", la_q[n0], 24'h000100);
        chk("wt_w16", ld_q[n0], 32'h12345678);

        // line left clean: conflict miss needs no write-back
        n0 = lw_q.size();
        do_req(0, 0, 0, 24'h000010, 0, hit, q, lat);
        chk("clean_lat", lat, 4);
        chk("clean_nops", lw_q.size() - n0, 1);
        chk("clean_op", lw_q[n0], 0);
        chk("clean_data", q, 32'h0000A510);

        // read-through on resident clean line
        n0 = lw_q.size();
        do_req(0, 0, 1, 24'h000010, 0, hit, q, lat);
        chk("rt_lat", lat, 4);
        chk("rt_hit", hit, 0);
        chk("rt_nops", lw_q.size() - n0, 1);
        chk("rt_op", lw_q[n0], 0);
        chk("rt_addr", la_q[n0], 24'h000000);

        // dirty sets 1 and 3, then flush
        do_req(1, 0, 0, 24'h000050, 32'h11111111, hit, q, lat);
        chk("s1_lat", lat, 4);
        do_req(1, 0, 0, 24'h0000D0, 32'h33333333, hit, q, lat);
        chk("s3_lat", lat, 4);
        n0 = lw_q.size();
        do_flush(lat);
        chk("fl_done", lat != 0, 1);
        chk("fl_nops", lw_q.size() - n0, 2);
        chk("fl_op0", lw_q[n0], 1);
        chk("fl_addr0", la_q[n0], 24'h000040);
        chk("fl_w16_0", ld_q[n0], 32'h11111111);
        chk("fl_op1", lw_q[n0+1], 1);
        chk("fl_addr1", la_q[n0+1], 24'h0000C0);
        chk("fl_w16_1", ld_q[n0+1], 32'h33333333);

        do_req(0, 0, 0, 24'h000050, 0, hit, q, lat);
        chk("pfl_lat", lat, 1);
        chk("pfl_hit", hit, 1);
        chk("pfl_data", q, 32'h11111111);

        // flush of an all-clean cache
        n0 = lw_q.size();
        do_flush(lat);
        chk("fl2_lat", lat, 5);
        chk("fl2_nops", lw_q.size() - n0, 0);

        // reset in the middle of a fill
        @(negedge clk);
        r_en = 1'b1;
        addr = 24'h000210;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_r_en) break;
        end
        chk("mid_fill", mem_r_en, 1);
        rst_l = 1'b0;
        #1;
        chk("mid_rst_mren", mem_r_en, 0);
        chk("mid_rst_mwen", mem_w_en, 0);
        chk("mid_rst_maddr", mem_addr, 0);
        r_en = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        n0 = lw_q.size();
        do_req(0, 0, 0, 24'h000050, 0, hit, q, lat);
        chk("prst_lat", lat, 4);
        chk("prst_hit", hit, 0);
        chk("prst_data", q, 32'h0040A510);
        chk("prst_nops", lw_q.size() - n0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
